// File: rtl/aes_axi_lite_slave.sv
// AXI-lite style slave bridging single transactions onto a simple register-file port.
// One outstanding access at a time; reads win over simultaneous writes.
module aes_axi_lite_slave #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] w_data_i,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [1:0]                b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   b_id_o,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]                r_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   r_id_o,
    output logic                      r_last_o,
    output logic [AXI_ADDR_WIDTH-1:0] address_o,
    output logic                      en_o,
    output logic                      we_o,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    input  logic [AXI_DATA_WIDTH-1:0] data_i
);

    typedef enum logic [2:0] {
        StIdle, StWaitW, StWrAcc, StWrResp, StRdAcc, StRdResp
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                resp_q;
    logic                      in_range;

    // Only the low 512 bytes of the address space map onto the register file.
    assign in_range = (addr_q[AXI_ADDR_WIDTH-1:9] == '0);

    assign b_resp_o = resp_q;
    assign b_id_o   = id_q;
    assign r_resp_o = resp_q;
    assign r_id_o   = id_q;
    assign r_data_o = rdata_q;

    always_comb begin
        state_d    = state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        ar_ready_o = 1'b0;
        b_valid_o  = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        en_o       = 1'b0;
        we_o       = 1'b0;
        address_o  = '0;
        data_o     = '0;
        case (state_q)
            StIdle: begin
                ar_ready_o = 1'b1;
                aw_ready_o = ~ar_valid_i;
                if (ar_valid_i) begin
                    state_d = StRdAcc;
                end else if (aw_valid_i) begin
                    state_d = StWaitW;
                end
            end
            StWaitW: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    state_d = StWrAcc;
                end
            end
            StWrAcc: begin
                en_o      = in_range;
                we_o      = in_range;
                address_o = in_range ? addr_q : '0;
                data_o    = in_range ? wdata_q : '0;
                state_d   = StWrResp;
            end
            StWrResp: begin
                b_valid_o = 1'b1;
                if (b_ready_i) begin
                    state_d = StIdle;
                end
            end
            StRdAcc: begin
                en_o      = in_range;
                address_o = in_range ? addr_q : '0;
                state_d   = StRdResp;
            end
            StRdResp: begin
                r_valid_o = 1'b1;
                r_last_o  = 1'b1;
                if (r_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            id_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (ar_valid_i) begin
                        addr_q <= ar_addr_i;
                        id_q   <= ar_id_i;
                    end else if (aw_valid_i) begin
                        addr_q <= aw_addr_i;
                        id_q   <= aw_id_i;
                    end
                end
                StWaitW: begin
                    if (w_valid_i) begin
                        wdata_q <= w_data_i;
                    end
                end
                StWrAcc: resp_q <= in_range ? 2'b00 : 2'b10;
                StRdAcc: begin
                    resp_q  <= in_range ? 2'b00 : 2'b10;
                    rdata_q <= in_range ? data_i : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_axi_lite_slave.sv
// Scoreboard bench for aes_axi_lite_slave: expected accesses and responses are queued by the
// driver and consumed by a negedge monitor as the DUT produces them.
module tb_aes_axi_lite_slave;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        aw_valid_i, aw_ready_o, w_valid_i, w_ready_o;
    logic [63:0] aw_addr_i, ar_addr_i, w_data_i;
    logic [9:0]  aw_id_i, ar_id_i, b_id_o, r_id_o;
    logic        b_valid_o, b_ready_i, ar_valid_i, ar_ready_o, r_valid_o, r_ready_i, r_last_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [63:0] r_data_o, address_o, data_o, data_i;
    logic        en_o, we_o;

    typedef struct {logic [63:0] addr; logic we; logic [63:0] data;} acc_t;
    typedef struct {logic [63:0] data; logic [1:0] resp; logic [9:0] id;} rsp_t;

    acc_t        acc_q[$];
    rsp_t        b_q[$];
    rsp_t        r_q[$];
    logic [63:0] rf      [64];
    logic [63:0] exp_mem [64];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    aes_axi_lite_slave dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_id_i(aw_id_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o), .b_id_o(b_id_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_id_i(ar_id_i), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_id_o(r_id_o), .r_last_o(r_last_o), .address_o(address_o),
        .en_o(en_o), .we_o(we_o), .data_o(data_o), .data_i(data_i)
    );

    // Register-file model; garbage when not enabled so a missing en_o gating shows up.
    always_comb begin
        data_i = 64'hA5A5_A5A5_A5A5_A5A5;
        if (en_o) data_i = rf[address_o[8:3]];
    end

    always @(posedge clk) begin
        if (en_o && we_o) rf[address_o[8:3]] <= data_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (en_o) begin
                if (acc_q.size() == 0) begin
                    check("en_unexpected", 64'(en_o), 64'd0);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    check("acc_addr", address_o, a.addr);
                    check("acc_we", 64'(we_o), 64'(a.we));
                    if (a.we) check("acc_data", data_o, a.data);
                end
            end
            if (b_valid_o && b_ready_i) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 64'(b_valid_o), 64'd0);
                end else begin
                    rsp_t b;
                    b = b_q.pop_front();
                    check("b_resp", 64'(b_resp_o), 64'(b.resp));
                    check("b_id", 64'(b_id_o), 64'(b.id));
                end
            end
            if (r_valid_o && r_ready_i) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 64'(r_valid_o), 64'd0);
                end else begin
                    rsp_t r;
                    r = r_q.pop_front();
                    check("r_data", r_data_o, r.data);
                    check("r_resp", 64'(r_resp_o), 64'(r.resp));
                    check("r_id", 64'(r_id_o), 64'(r.id));
                    check("r_last", 64'(r_last_o), 64'd1);
                end
            end
        end
    end

    task automatic expect_write(input logic [63:0] addr, input logic [9:0] id,
                                input logic [63:0] data);
        logic ok;
        ok = (addr[63:9] == '0);
        if (ok) begin
            acc_q.push_back('{addr: addr, we: 1'b1, data: data});
            exp_mem[addr[8:3]] = data;
        end
        b_q.push_back('{data: 64'd0, resp: ok ? 2'b00 : 2'b10, id: id});
    endtask

    task automatic expect_read(input logic [63:0] addr, input logic [9:0] id);
        logic ok;
        ok = (addr[63:9] == '0);
        if (ok) acc_q.push_back('{addr: addr, we: 1'b0, data: 64'd0});
        r_q.push_back('{data: ok ? exp_mem[addr[8:3]] : 64'd0, resp: ok ? 2'b00 : 2'b10, id: id});
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [9:0] id,
                            input logic [63:0] data);
        int n;
        logic ok;
        ok = (addr[63:9] == '0);
        expect_write(addr, id, data);
        aw_valid_i = 1'b1; aw_addr_i = addr; aw_id_i = id;
        w_valid_i  = 1'b1; w_data_i = data;
        n = 0;
        @(negedge clk);
        check("w_before_aw", 64'(w_ready_o), 64'd0);
        while (!aw_ready_o && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("aw_timeout", 64'd0, 64'd1);
        @(posedge clk); #1 aw_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!w_ready_o && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("w_timeout", 64'd0, 64'd1);
        @(posedge clk); #1 w_valid_i = 1'b0;
        @(negedge clk);
        check("wr_en_lat", 64'(en_o), 64'(ok));
        check("wr_we_lat", 64'(we_o), 64'(ok));
        @(negedge clk);
        check("b_valid_lat", 64'(b_valid_o), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [9:0] id);
        int n;
        logic ok;
        ok = (addr[63:9] == '0);
        expect_read(addr, id);
        ar_valid_i = 1'b1; ar_addr_i = addr; ar_id_i = id;
        n = 0;
        @(negedge clk);
        while (!ar_ready_o && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("ar_timeout", 64'd0, 64'd1);
        @(posedge clk); #1 ar_valid_i = 1'b0;
        @(negedge clk);
        check("rd_en_lat", 64'(en_o), 64'(ok));
        check("rd_we", 64'(we_o), 64'd0);
        @(negedge clk);
        check("r_valid_lat", 64'(r_valid_o), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            rf[i]      = 64'h1000 + 64'(i);
            exp_mem[i] = 64'h1000 + 64'(i);
        end
        rf[12] = 64'h1234; exp_mem[12] = 64'h1234;
        rst_i = 1'b1;
        aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0; b_ready_i = 1; r_ready_i = 1;
        aw_addr_i = 0; aw_id_i = 0; ar_addr_i = 0; ar_id_i = 0; w_data_i = 0;
        #12;
        check("rst_valids", {60'd0, b_valid_o, r_valid_o, en_o, we_o}, 64'd0);
        check("rst_outs", address_o | data_o | r_data_o, 64'd0);
        check("rst_meta", {48'd0, b_resp_o, r_resp_o, b_id_o, r_id_o, r_last_o, w_ready_o},
              64'd0);
        @(posedge clk); #1 rst_i = 1'b0;

        do_write(64'h08, 10'd3, 64'h0000_0000_DEAD_BEEF);
        do_read(64'h60, 10'd5);
        do_read(64'h08, 10'd6);
        do_write(64'h1F8, 10'h3FF, 64'hFEDC_BA98_7654_3210);
        do_read(64'h1F8, 10'h2AA);
        do_read(64'h200, 10'd7);
        do_write(64'h400, 10'd9, 64'h1111_2222_3333_4444);
        do_read(64'h8000_0000_0000_0010, 10'd8);

        // Simultaneous AR/AW: read first, then the write.
        expect_read(64'h10, 10'd11);
        expect_write(64'h18, 10'd12, 64'hCAFE_F00D_0000_0001);
        ar_valid_i = 1; ar_addr_i = 64'h10; ar_id_i = 10'd11;
        aw_valid_i = 1; aw_addr_i = 64'h18; aw_id_i = 10'd12; w_data_i = 64'hCAFE_F00D_0000_0001;
        @(negedge clk);
        check("both_aw_ready", 64'(aw_ready_o), 64'd0);
        check("both_ar_ready", 64'(ar_ready_o), 64'd1);
        @(posedge clk); #1 ar_valid_i = 0;
        @(negedge clk);
        check("both_aw_hold_acc", 64'(aw_ready_o), 64'd0);
        @(negedge clk);
        check("both_aw_hold_resp", 64'(aw_ready_o), 64'd0);
        @(negedge clk);
        check("both_aw_after", 64'(aw_ready_o), 64'd1);
        @(posedge clk); #1 aw_valid_i = 0; w_valid_i = 1;
        @(negedge clk);
        check("both_w_ready", 64'(w_ready_o), 64'd1);
        @(posedge clk); #1 w_valid_i = 0;
        @(negedge clk);
        check("both_wr_en", 64'(en_o & we_o), 64'd1);
        @(negedge clk);
        check("both_b_valid", 64'(b_valid_o), 64'd1);
        @(posedge clk); #1;

        // R back-pressure: response held stable, AW blocked.
        r_ready_i = 0;
        expect_read(64'h08, 10'd13);
        ar_valid_i = 1; ar_addr_i = 64'h08; ar_id_i = 10'd13;
        @(posedge clk); #1 ar_valid_i = 0;
        aw_valid_i = 1; aw_addr_i = 64'h20; aw_id_i = 10'd14;
        @(negedge clk);
        @(negedge clk);
        repeat (5) begin
            check("stall_r_valid", 64'(r_valid_o), 64'd1);
            check("stall_r_data", r_data_o, 64'h0000_0000_DEAD_BEEF);
            check("stall_r_id", 64'(r_id_o), 64'd13);
            check("stall_aw_ready", 64'(aw_ready_o), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 r_ready_i = 1;
        @(posedge clk); #1 aw_valid_i = 0;
        do_write(64'h20, 10'd14, 64'h0BAD_F00D_0BAD_F00D);
        do_read(64'h20, 10'd15);

        // Reset while waiting for W drops the write.
        aw_valid_i = 1; aw_addr_i = 64'h30; aw_id_i = 10'd4;
        @(posedge clk); #1 aw_valid_i = 0;
        @(negedge clk);
        check("rst_in_waitw", 64'(w_ready_o), 64'd1);
        #2 rst_i = 1;
        #1;
        check("rst_w_ready", 64'(w_ready_o), 64'd0);
        check("rst_en", 64'(en_o), 64'd0);
        @(posedge clk); #1 rst_i = 0; w_valid_i = 1; w_data_i = 64'h5555;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_en", 64'(en_o), 64'd0);
            check("post_rst_b", 64'(b_valid_o), 64'd0);
        end
        @(posedge clk); #1 w_valid_i = 0;
        do_read(64'h30, 10'd16);

        repeat (3) @(posedge clk);
        check("acc_left", 64'(acc_q.size()), 64'd0);
        check("b_left", 64'(b_q.size()), 64'd0);
        check("r_left", 64'(r_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
